// File: rtl/pe_mc_accum.sv
// rtl/pe_mc_accum.sv - KxK multiply, pipelined adder tree, multi-channel accumulate with valid/ready.
// Optional build macro PE_RELU_EN clamps negative signed results to zero.
module pe_mc_accum #(
   parameter int PIC_BITS    = 2,
   parameter int WEIGHT_BITS = 3,
   parameter int KERNEL_SIZE = 5,
   parameter int CHANNEL     = 4,
   parameter int SIGNED      = 0,
   parameter int RESULT_BITS = PIC_BITS + WEIGHT_BITS
                               + $clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNEL) + SIGNED
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0][PIC_BITS-1:0]    pic,
   input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0][WEIGHT_BITS-1:0] weight,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic [RESULT_BITS-1:0]                              result,
   output logic [$clog2(CHANNEL):0]                            ch_idx
);
   localparam int KK = KERNEL_SIZE*KERNEL_SIZE;
   localparam int T  = $clog2(KK);
   localparam int PW = PIC_BITS + WEIGHT_BITS;
   localparam int SW = PW + T;
   localparam int CW = $clog2(CHANNEL) + 1;
   localparam logic [CW-1:0] CH_LAST = CW'(CHANNEL - 1);
   localparam logic SX = (SIGNED != 0);

   function automatic int cnt(input int l);
      return (KK + (1 << l) - 1) >> l;
   endfunction

   logic en, accept;
   logic [KK-1:0][PIC_BITS-1:0]    pic_q;
   logic [KK-1:0][WEIGHT_BITS-1:0] weight_q;
   logic [SW-1:0] tree_d [T+1][KK];
   logic [SW-1:0] tree_q [T+1][KK];
   logic signed [PIC_BITS:0]    p_x;
   logic signed [WEIGHT_BITS:0] w_x;
   logic signed [PW+1:0]        prod;
   // Tag bit s follows stage s: 0 input capture, 1 products, 1+l tree level l.
   logic [T+1:0] v_q, v_d, first_q, first_d, last_q, last_d;
   logic [CW-1:0] ch_idx_q, ch_idx_d;
   logic [RESULT_BITS-1:0] acc_q, acc_d, result_q, result_d;
   logic [RESULT_BITS-1:0] tree_sum, final_sum, load_val;
   logic out_valid_q, out_valid_d;

   assign en        = !(out_valid_q && !out_ready);
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ch_idx    = ch_idx_q;

   // Every tree node is kept sign-extended to the final tree width, so sums never truncate.
   always_comb begin
      p_x  = '0;
      w_x  = '0;
      prod = '0;
      for (int l = 0; l <= T; l++)
         for (int i = 0; i < KK; i++)
            tree_d[l][i] = '0;
      for (int i = 0; i < KK; i++) begin
         p_x  = {SX & pic_q[i][PIC_BITS-1], pic_q[i]};
         w_x  = {SX & weight_q[i][WEIGHT_BITS-1], weight_q[i]};
         prod = (PW+2)'(p_x) * (PW+2)'(w_x);
         tree_d[0][i] = SW'(prod);
      end
      for (int l = 1; l <= T; l++)
         for (int i = 0; i < (KK + 1) / 2; i++)
            if (i < cnt(l)) begin
               if (2*i + 1 < cnt(l-1))
                  tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][(2*i + 1) % KK];
               else
                  tree_d[l][i] = tree_q[l-1][2*i];
            end
   end

   assign tree_sum  = SX ? RESULT_BITS'($signed(tree_q[T][0])) : RESULT_BITS'(tree_q[T][0]);
   assign final_sum = first_q[T+1] ? tree_sum : acc_q + tree_sum;

`ifdef PE_RELU_EN
   assign load_val = (SX && final_sum[RESULT_BITS-1]) ? '0 : final_sum;
`else
   assign load_val = final_sum;
`endif

   always_comb begin
      v_d         = v_q;
      first_d     = first_q;
      last_d      = last_q;
      ch_idx_d    = ch_idx_q;
      acc_d       = acc_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      if (en) begin
         v_d     = {v_q[T:0], accept};
         first_d = {first_q[T:0], ch_idx_q == '0};
         last_d  = {last_q[T:0], ch_idx_q == CH_LAST};
         if (accept)
            ch_idx_d = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + 1'b1;
         // en with out_valid set means the downstream took the result this cycle.
         if (out_valid_q)
            out_valid_d = 1'b0;
         if (v_q[T+1]) begin
            acc_d = final_sum;
            if (last_q[T+1]) begin
               result_d    = load_val;
               out_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q         <= '0;
         first_q     <= '0;
         last_q      <= '0;
         ch_idx_q    <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         v_q         <= v_d;
         first_q     <= first_d;
         last_q      <= last_d;
         ch_idx_q    <= ch_idx_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         pic_q    <= pic;
         weight_q <= weight;
         tree_q   <= tree_d;
      end
   end
endmodule

// File: doc/pe_mc_accum.md
Name: pe_mc_accum

Overview:
- Parametrised successor processing element for the convolution datapath.
- Accepts one KERNEL_SIZE x KERNEL_SIZE window per beat, one channel at a time. Each beat: elementwise multiply, pipelined adder-tree reduction, then accumulation across CHANNEL consecutive beats into one output pixel.
- Adds over the previous generation: valid/ready handshake with backpressure, signed/unsigned mode, and multi-beat channel accumulation.
- Sits between the window/line-buffer stage and the pooling/activation stage.

Parameters:
- PIC_BITS, 2, pixel operand width.
- WEIGHT_BITS, 3, weight operand width.
- KERNEL_SIZE, 5, window side; KK = KERNEL_SIZE*KERNEL_SIZE taps.
- CHANNEL, 4, input channels accumulated per output (>=1).
- SIGNED, 0, 0 = both operands unsigned; 1 = both two's complement.
- RESULT_BITS, PIC_BITS+WEIGHT_BITS+$clog2(KK*CHANNEL)+SIGNED, output width; the default is sufficient, never overflows.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  window beat valid.
- in_ready  out  1  PE can accept a beat this cycle.
- pic  in  [PIC_BITS-1:0] x KK  window pixels for the current channel.
- weight  in  [WEIGHT_BITS-1:0] x KK  kernel taps for the current channel.
- out_valid  out  1  result holds a complete output pixel.
- out_ready  in  1  downstream accepts result.
- result  out  RESULT_BITS  sum over all CHANNEL beats of sum(pic[i]*weight[i]).
- ch_idx  out  $clog2(CHANNEL)+1  channel index of the next beat to be accepted (debug/status).

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, result=0, ch_idx=0, all pipeline valid bits and tags cleared, accumulator=0. in_ready=1 in the first cycle after reset. Beats in flight are discarded.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. Beat accepted when in_valid && in_ready.
- Stall: when en=0, every pipeline register, tag, accumulator and ch_idx holds its value.
- Stage 1: register KK products. Extension: PIC_BITS+WEIGHT_BITS wide; sign-extend if SIGNED=1, else zero-extend.
- Stages 2..T+1, T=$clog2(KK): binary adder tree, one registered level per stage. Odd element passes through the level registered. Each level grows by 1 bit, sign-extended per SIGNED.
- Stage T+2: accumulator.
  - first tag set: acc <= tree sum.
  - otherwise: acc <= acc + tree sum.
  - last tag set: result <= final sum, out_valid <= 1.
- Tags: each accepted beat carries a valid, first (ch_idx==0) and last (ch_idx==CHANNEL-1) bit down the pipe. Bubbles (valid=0) do not touch acc.
- ch_idx: increments on each accepted beat; wraps to 0 after CHANNEL-1. CHANNEL=1: every beat is both first and last.
- Latency: out_valid rises T+2 cycles after the posedge accepting the last-channel beat, when no stall occurs. KERNEL_SIZE=5: T=5, latency 7. KERNEL_SIZE=3: T=4, latency 6.
- Throughput: one beat/cycle with no backpressure; one output pixel per CHANNEL beats.
- Output clear: out_valid && out_ready with no new last beat arriving -> out_valid <= 0 next cycle.
- Simultaneous: out_valid && out_ready while a new last beat reaches the accumulator -> result replaced, out_valid stays 1 (back-to-back, no bubble).
- Holding: result is stable while out_valid && !out_ready.
- in_valid=0 mid-pixel: partial sum is held in acc; accumulation resumes with the next accepted beat.
- Width rule: all internal sums are computed at full width, with no truncation before result.

Optional Feature:
- Macro PE_RELU_EN.
- Defined: at the accumulator stage, a last-beat final sum that is negative (SIGNED=1) is loaded into result as 0. Unsigned mode is unaffected.
- Undefined: result is the raw signed/unsigned sum. Latency is identical in both builds.

Test Plan:
- SIGNED=0, K=5, CHANNEL=1, all pic=3, all weight=7, one beat -> out_valid exactly 7 cycles later, result=525, then drops after out_ready.
- SIGNED=0, CHANNEL=4, beats with all pic=1 and weights 1,2,3,4 per channel -> single out_valid, result=250, ch_idx back to 0.
- SIGNED=1, PIC_BITS=3, WEIGHT_BITS=3, CHANNEL=2: ch0 pic=-4, w=3; ch1 pic=1, w=1 -> result=-275.
  - With PE_RELU_EN defined -> result=0.
- Backpressure: stream 3 pixels (CHANNEL=2) with out_ready=0 -> in_ready falls once first result is valid; result stable; raising out_ready drains all 3 results in order with no loss or duplication.
- Bubbles: CHANNEL=3, insert 2 idle cycles between ch1 and ch2 beats -> correct sum, out_valid delayed by exactly 2 cycles.
- Reset mid-pixel after 2 of 4 channels -> next cycle out_valid=0, ch_idx=0, in_ready=1; a following full pixel yields only its own sum.
